alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters, req0 and req1.
//  Each requester uses a valid/ready request channel. Responses leave on one
//  valid/ready channel, tagged with the id of the requester that issued them.
//  Sits between the two issue sources and the single ALU instance, and owns
//  the ALU's A/B/OP inputs.
// PARAMETERS
//  W    8  operand/result width
//  OPS  3  opcode width (000 add, 001 shr, 010 shl, 011 parity-insert, others illegal)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    reset, asynchronous, active-high
//  req0_valid in   1    requester 0 has an operation
//  req0_ready out  1    requester 0 operation accepted this cycle
//  req0_op    in   OPS  requester 0 opcode
//  req0_a     in   W    requester 0 operand A
//  req0_b     in   W    requester 0 operand B
//  req1_*     -    -    same set as req0_* (valid, ready, op, a, b) for requester 1
//  alu_op     out  OPS  opcode driven to shared ALU
//  alu_a      out  W    operand A driven to shared ALU
//  alu_b      out  W    operand B driven to shared ALU
//  alu_out    in   W    result returned by shared ALU (combinational)
//  rsp_valid  out  1    response available
//  rsp_ready  in   1    consumer takes response
//  rsp_id     out  1    0 = req0 issued it, 1 = req1 issued it
//  rsp_data   out  W    captured ALU result
//  rsp_zero   out  1    rsp_data == 0
//  rsp_err    out  1    illegal opcode (op > 3), or op==3 with b >= W
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE. Reset state is IDLE.
//  - IDLE: if any reqN_valid, grant a winner and raise that reqN_ready for
//    this cycle only. Latch winner's op/a/b and id; go to EXEC.
//    No valid: stay in IDLE.
//  - reqN_ready is 1 only in IDLE, only to the winner, and may depend on
//    reqN_valid. A requester holds valid/op/a/b stable until it sees ready.
//  - Arbitration is round-robin. last_grant is a register, reset to 1, so
//    req0 wins the first tie. When both are valid, the requester that is not
//    last_grant wins. A lone valid always wins.
//  - alu_op/alu_a/alu_b always show the latched registers, held between ops
//    (reset 0).
//  - EXEC (one cycle): register alu_out into rsp_data. Compute rsp_err from
//    the latched op/b. Go to RESP.
//  - RESP: rsp_valid=1; rsp_data, rsp_id and rsp_err held stable.
//    On rsp_ready=1, go to IDLE.
//  - Requests arriving during EXEC/RESP wait. No request is accepted in the
//    same cycle a response is taken.
//  - Latency: accept in cycle t -> rsp_valid=1 in cycle t+2.
//    Maximum throughput is 1 op per 3 cycles.
//  - rsp_zero is combinational from rsp_data.
//  - Illegal ops still flow through. rsp_data is whatever the ALU returned
//    (0 for illegal opcodes) and rsp_err=1.
//  - Reset (async, any state): state=IDLE, last_grant=1, and every output
//    goes to 0 (all ready, rsp_* and alu_* outputs).
//    An in-flight operation is discarded and no response is issued.
// TESTING
//  1. req0 op=000 a=8'h05 b=8'h03, rsp_ready=1
//     -> req0_ready at t, rsp_valid at t+2; rsp_data=8'h08, rsp_id=0,
//        rsp_err=0, rsp_zero=0.
//  2. Both valid every cycle from reset
//     -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
//     The losing requester's ready stays 0.
//  3. op=001 a=8'hF0 b=8'h04 with rsp_ready=0 for 5 cycles
//     -> rsp_valid held, rsp_data=8'h0F stable, req1_valid gets no ready
//        until the response is taken.
//  4. op=010 a=8'h80 b=8'h01 -> rsp_data=8'h00, rsp_zero=1.
//     op=011 a=8'h07 b=8'h01 -> rsp_data=8'h07 (bit1 set to parity 1), rsp_err=0.
//  5. op=111 a=8'h12 b=8'h34 -> rsp_data=8'h00, rsp_err=1.
//     op=011 b=8'h09 -> rsp_err=1.
//  6. rst asserted mid-EXEC -> outputs 0 immediately, no rsp_valid after
//     release. With both valid, the next grant goes to req0.

Source files
------------

// File: rtl/alu_share_if.sv
// Bundles the two request channels, the shared-ALU operand/result bus and the
// tagged response channel between the issue sources and alu_share_arbiter.
interface alu_share_if #(
  parameter int W   = 8,
  parameter int OPS = 3
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPS-1:0] req0_op;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPS-1:0] req1_op;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;

  logic [OPS-1:0] alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_out;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_zero;
  logic           rsp_err;

  // The arbiter side: serves both requesters and owns the ALU inputs.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_out,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_out,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters; each
// accepted operation is executed once and returned on a tagged response channel.
module alu_share_arbiter #(
  parameter int W   = 8,
  parameter int OPS = 3
) (
  input  logic        clk,
  input  logic        rst,
  alu_share_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [OPS-1:0] op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic           any_valid;
  logic           winner;
  logic           grant;

  function automatic logic op_error(input logic [OPS-1:0] op, input logic [W-1:0] b);
    return (op > OPS'(3)) || ((op == OPS'(3)) && (32'(b) >= 32'(W)));
  endfunction

  // Ready is masked by rst so that no handshake can appear while reset is held.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    winner    = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    grant     = (state_q == IDLE) & any_valid & ~rst;
  end

  assign bus.req0_ready = grant & ~winner;
  assign bus.req1_ready = grant &  winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          op_d         = winner ? bus.req1_op : bus.req0_op;
          a_d          = winner ? bus.req1_a  : bus.req0_a;
          b_d          = winner ? bus.req1_b  : bus.req0_b;
          id_d         = winner;
          last_grant_d = winner;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = bus.alu_out;
        rsp_err_d   = op_error(op_q, b_q);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  // Qualified by valid so the flag is 0 whenever no response is presented.
  assign bus.rsp_zero  = rsp_valid_q & (rsp_data_q == '0);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter with a transaction-level
// reference model of the arbitration, latency and response rules.
module tb_alu_share_arbiter;

  logic clk;
  logic rst;

  alu_share_if #(.W(8), .OPS(3)) bus ();

  alu_share_arbiter #(.W(8), .OPS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a >> b;
      3'd2: r = a << b;
      3'd3: begin
        r = a;
        if (b < 8'd8) r[b[2:0]] = ^a;
      end
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic err_fn(input logic [2:0] op, input logic [7:0] b);
    return (op > 3'd3) || ((op == 3'd3) && (b >= 8'd8));
  endfunction

  // Shared ALU instance modelled behaviourally.
  assign bus.alu_out = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  int tests;
  int fails;
  int cyc;

  logic       v [2];
  logic [2:0] op_r [2];
  logic [7:0] a_r [2];
  logic [7:0] b_r [2];
  logic       rsp_rdy;
  logic       rst_v;
  bit         rand_mode;
  bit         auto_mode;

  bit         got_acc [2];
  bit         got_rsp;
  logic       o_r0, o_r1, o_valid, o_id, o_err, o_zero;
  logic [7:0] o_data;

  bit         m_busy;
  int         m_rdy_cyc;
  logic       m_id;
  logic [7:0] m_data;
  logic       m_err;
  logic       m_last;
  logic [2:0] m_op;
  logic [7:0] m_a, m_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = 1'b1;
    m_op   = 3'd0;
    m_a    = 8'd0;
    m_b    = 8'd0;
  endtask

  task automatic check_zero();
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_rsp_valid",  bus.rsp_valid, 0);
    chk("rst_rsp_id",     bus.rsp_id, 0);
    chk("rst_rsp_data",   bus.rsp_data, 0);
    chk("rst_rsp_err",    bus.rsp_err, 0);
    chk("rst_rsp_zero",   bus.rsp_zero, 0);
    chk("rst_alu_op",     bus.alu_op, 0);
    chk("rst_alu_a",      bus.alu_a, 0);
    chk("rst_alu_b",      bus.alu_b, 0);
  endtask

  task automatic new_req(input int n);
    op_r[n] = 3'($urandom_range(0, 7));
    a_r[n]  = 8'($urandom);
    b_r[n]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
    v[n]    = 1'b1;
  endtask

  task automatic load(input int n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    op_r[n] = op;
    a_r[n]  = a;
    b_r[n]  = b;
    v[n]    = 1'b1;
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, then
  // advance the model to what the next rising edge must produce.
  task automatic cycle();
    logic w, er0, er1, ev;
    @(negedge clk);
    rst            = rst_v;
    bus.req0_valid = v[0];
    bus.req0_op    = op_r[0];
    bus.req0_a     = a_r[0];
    bus.req0_b     = b_r[0];
    bus.req1_valid = v[1];
    bus.req1_op    = op_r[1];
    bus.req1_a     = a_r[1];
    bus.req1_b     = b_r[1];
    bus.rsp_ready  = rsp_rdy;
    #1;
    o_r0    = bus.req0_ready;
    o_r1    = bus.req1_ready;
    o_valid = bus.rsp_valid;
    o_id    = bus.rsp_id;
    o_data  = bus.rsp_data;
    o_err   = bus.rsp_err;
    o_zero  = bus.rsp_zero;
    got_acc[0] = 1'b0;
    got_acc[1] = 1'b0;
    got_rsp    = 1'b0;
    if (rst_v) begin
      check_zero();
      model_reset();
    end else begin
      w   = 1'b0;
      er0 = 1'b0;
      er1 = 1'b0;
      if (!m_busy && (v[0] || v[1])) begin
        if (v[0] && v[1]) w = ~m_last;
        else              w = v[1];
        er0 = ~w;
        er1 = w;
      end
      ev = m_busy && (cyc >= m_rdy_cyc);
      chk("req0_ready", o_r0, er0);
      chk("req1_ready", o_r1, er1);
      chk("rsp_valid",  o_valid, ev);
      chk("alu_op", bus.alu_op, m_op);
      chk("alu_a",  bus.alu_a, m_a);
      chk("alu_b",  bus.alu_b, m_b);
      if (ev) begin
        chk("rsp_id",   o_id, m_id);
        chk("rsp_data", o_data, m_data);
        chk("rsp_err",  o_err, m_err);
        chk("rsp_zero", o_zero, (m_data == 8'h00));
      end
      got_acc[0] = o_r0 && v[0];
      got_acc[1] = o_r1 && v[1];
      got_rsp    = o_valid && rsp_rdy;
      if (ev && rsp_rdy) m_busy = 1'b0;
      if (er0 || er1) begin
        m_busy    = 1'b1;
        m_rdy_cyc = cyc + 2;
        m_id      = w;
        m_op      = op_r[w];
        m_a       = a_r[w];
        m_b       = b_r[w];
        m_data    = alu_fn(op_r[w], a_r[w], b_r[w]);
        m_err     = err_fn(op_r[w], b_r[w]);
        m_last    = w;
      end
    end
    cyc++;
    for (int n = 0; n < 2; n++) begin
      if (got_acc[n]) v[n] = 1'b0;
      if (!v[n] && (auto_mode || (rand_mode && $urandom_range(0, 1) == 1))) new_req(n);
    end
    if (rand_mode) rsp_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_acc(input int n);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (got_acc[n]) done = 1'b1;
    end
    if (!done) timeout("wait_acc");
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (v[0] || v[1] || m_busy); k++) cycle();
    if (v[0] || v[1] || m_busy) timeout("drain");
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic id, output logic [7:0] data, output logic err,
                       output logic zero, output int lat);
    int  acc_c;
    bit  done;
    acc_c = -100;
    done  = 1'b0;
    lat   = -1;
    id    = 1'bx;
    data  = 8'hxx;
    err   = 1'bx;
    zero  = 1'bx;
    load(0, op, a, b);
    rsp_rdy = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (got_acc[0]) acc_c = cyc - 1;
      if (got_rsp) begin
        id   = o_id;
        data = o_data;
        err  = o_err;
        zero = o_zero;
        lat  = (cyc - 1) - acc_c;
        done = 1'b1;
      end
    end
    if (!done) timeout("do_op");
  endtask

  logic       r_id, r_err, r_zero;
  logic [7:0] r_data;
  int         r_lat;
  logic       gseq [$];
  logic       rseq [$];
  bit         seen;

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    rand_mode = 1'b0;
    auto_mode = 1'b0;
    rsp_rdy   = 1'b0;
    rst       = 1'b1;
    rst_v     = 1'b1;
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; op_r[n] = 3'd0; a_r[n] = 8'd0; b_r[n] = 8'd0;
    end
    model_reset();
    cycle();
    cycle();
    rst_v = 1'b0;

    // Single add from requester 0, fixed two-cycle latency.
    do_op(3'b000, 8'h05, 8'h03, r_id, r_data, r_err, r_zero, r_lat);
    chk("t1_data", r_data, 8'h08);
    chk("t1_id",   r_id, 0);
    chk("t1_err",  r_err, 0);
    chk("t1_zero", r_zero, 0);
    chk("t1_lat",  r_lat, 2);

    // Both requesters valid every cycle straight out of reset.
    rst_v = 1'b1;
    new_req(0);
    new_req(1);
    auto_mode = 1'b1;
    rsp_rdy   = 1'b1;
    cycle();
    rst_v = 1'b0;
    for (int k = 0; k < 40 && rseq.size() < 4; k++) begin
      cycle();
      if (got_acc[0]) gseq.push_back(1'b0);
      if (got_acc[1]) gseq.push_back(1'b1);
      if (got_rsp) rseq.push_back(o_id);
    end
    auto_mode = 1'b0;
    if (gseq.size() < 4 || rseq.size() < 4) timeout("t2_seq");
    else begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_grant", gseq[i], i % 2);
        chk("t2_rsp_id", rseq[i], i % 2);
      end
    end
    drain();

    // Response back-pressure holds data stable and blocks new grants.
    load(0, 3'b001, 8'hF0, 8'h04);
    rsp_rdy = 1'b0;
    wait_acc(0);
    load(1, 3'b000, 8'h11, 8'h22);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      cycle();
      if (o_valid) seen = 1'b1;
    end
    if (!seen) timeout("t3_rsp_valid");
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_valid_held", o_valid, 1);
      chk("t3_data", o_data, 8'h0F);
      chk("t3_req1_blocked", o_r1, 0);
    end
    rsp_rdy = 1'b1;
    cycle();
    chk("t3_taken", got_rsp, 1);
    chk("t3_no_same_cycle_grant", o_r1, 0);
    cycle();
    chk("t3_req1_granted", got_acc[1], 1);
    drain();

    do_op(3'b010, 8'h80, 8'h01, r_id, r_data, r_err, r_zero, r_lat);
    chk("t4_shl_data", r_data, 8'h00);
    chk("t4_shl_zero", r_zero, 1);
    do_op(3'b011, 8'h07, 8'h01, r_id, r_data, r_err, r_zero, r_lat);
    chk("t4_par_data", r_data, 8'h07);
    chk("t4_par_err",  r_err, 0);

    do_op(3'b111, 8'h12, 8'h34, r_id, r_data, r_err, r_zero, r_lat);
    chk("t5_ill_data", r_data, 8'h00);
    chk("t5_ill_err",  r_err, 1);
    do_op(3'b011, 8'h5A, 8'h09, r_id, r_data, r_err, r_zero, r_lat);
    chk("t5_par_err",  r_err, 1);

    // Asynchronous reset in the middle of EXEC.
    load(0, 3'b000, 8'h21, 8'h13);
    rsp_rdy = 1'b1;
    wait_acc(0);
    @(negedge clk);
    #1;
    chk("t6_in_exec_alu_a", bus.alu_a, 8'h21);
    #1;
    rst = 1'b1;
    #1;
    check_zero();
    cyc++;
    model_reset();
    load(0, 3'b000, 8'h01, 8'h02);
    load(1, 3'b000, 8'h03, 8'h04);
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    cycle();
    chk("t6_first_grant_req0", got_acc[0], 1);
    chk("t6_first_grant_not_req1", got_acc[1], 0);
    drain();

    rand_mode = 1'b1;
    rsp_rdy   = 1'b1;
    repeat (400) cycle();
    rand_mode = 1'b0;
    rsp_rdy   = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
